tug_of_war_field: RTL and testbench

Playfield and scoring stage of the tug-of-war game. It consumes the one-cycle player pulses produced by the button input-processing stage and moves a single lit LED along an N-LED strip. When the light is pushed off an edge, it awards the round and keeps a saturating per-player score. After a short pause it recentres, and it ends the match when either score reaches its maximum.

---
 rtl/tug_of_war_field_if.sv | 18 +
 rtl/tug_of_war_field.sv | 107 ++++++++++
 tb/tb_tug_of_war_field.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tug_of_war_field_if.sv
// Player pulse inputs and playfield/score outputs of the tug-of-war field stage.
interface tug_of_war_field_if #(
    parameter int N_LEDS    = 9,
    parameter int SCORE_MAX = 7
);
    localparam int SW = $clog2(SCORE_MAX + 1);

    logic              p1;
    logic              p2;
    logic [N_LEDS-1:0] leds;
    logic [1:0]        winner;
    logic [SW-1:0]     score1;
    logic [SW-1:0]     score2;
    logic              match_over;

    modport master (output p1, p2, input leds, winner, score1, score2, match_over);
    modport slave  (input p1, p2, output leds, winner, score1, score2, match_over);
endinterface

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: moves a lit LED on player pulses, scores push-outs,
// pauses between rounds and latches the end of the match.
module tug_of_war_field #(
    parameter int N_LEDS       = 9,
    parameter int SCORE_MAX    = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input logic            clk,
    input logic            reset_n,
    tug_of_war_field_if.slave bus
);
    localparam int PW = $clog2(N_LEDS);
    localparam int SW = $clog2(SCORE_MAX + 1);
    localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PW-1:0] CTR  = PW'((N_LEDS - 1) / 2);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

    typedef enum logic [1:0] {PLAY, PAUSE, DONE} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     pos, pos_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [SW-1:0]     s1, s1_n, s2, s2_n;
    logic [1:0]        win, win_n;
    logic [N_LEDS-1:0] leds_q, leds_n;
    logic              over_q;
    logic              mv1, mv2;

    // A simultaneous press by both players cancels out.
    assign mv1 = bus.p1 & ~bus.p2;
    assign mv2 = bus.p2 & ~bus.p1;

    always_comb begin
        state_n = state;
        pos_n   = pos;
        cnt_n   = cnt;
        s1_n    = s1;
        s2_n    = s2;
        win_n   = win;
        case (state)
            PLAY: begin
                if (mv1) begin
                    if (pos == LAST) begin
                        s1_n    = s1 + 1'b1;
                        win_n   = 2'b10;
                        pos_n   = CTR;
                        cnt_n   = CW'(PAUSE_CYCLES - 1);
                        state_n = (s1_n == SW'(SCORE_MAX)) ? DONE : PAUSE;
                    end else begin
                        pos_n = pos + 1'b1;
                    end
                end else if (mv2) begin
                    if (pos == '0) begin
                        s2_n    = s2 + 1'b1;
                        win_n   = 2'b01;
                        pos_n   = CTR;
                        cnt_n   = CW'(PAUSE_CYCLES - 1);
                        state_n = (s2_n == SW'(SCORE_MAX)) ? DONE : PAUSE;
                    end else begin
                        pos_n = pos - 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (cnt == '0) state_n = PLAY;
                else           cnt_n   = cnt - 1'b1;
            end
            default: ;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        case (state_n)
            PLAY:    leds_n = ONE << pos_n;
            PAUSE:   leds_n = '0;
            default: leds_n = '1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= PLAY;
            pos    <= CTR;
            cnt    <= '0;
            s1     <= '0;
            s2     <= '0;
            win    <= 2'b00;
            leds_q <= ONE << CTR;
            over_q <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            cnt    <= cnt_n;
            s1     <= s1_n;
            s2     <= s2_n;
            win    <= win_n;
            leds_q <= leds_n;
            over_q <= (state_n == DONE);
        end
    end

    assign bus.leds       = leds_q;
    assign bus.winner     = win;
    assign bus.score1     = s1;
    assign bus.score2     = s2;
    assign bus.match_over = over_q;
endmodule

// File: tb/tb_tug_of_war_field.sv
// Bench for tug_of_war_field: a default instance and a SCORE_MAX=2 instance,
// directed scenarios then random pulses, against a round/score model.
module tb_tug_of_war_field;
    localparam int N     = 9;
    localparam int C     = (N - 1) / 2;
    localparam int PAUSE = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tug_of_war_field_if #(.N_LEDS(N), .SCORE_MAX(7)) ia ();
    tug_of_war_field_if #(.N_LEDS(N), .SCORE_MAX(2)) ib ();

    tug_of_war_field #(.N_LEDS(N), .SCORE_MAX(7), .PAUSE_CYCLES(PAUSE)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ia.slave));
    tug_of_war_field #(.N_LEDS(N), .SCORE_MAX(2), .PAUSE_CYCLES(PAUSE)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ib.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: light position, scores, last winner, pause cycles left, match ended.
    int smax [2] = '{7, 2};
    int m_pos[2], m_s1[2], m_s2[2], m_win[2], m_pl[2];
    bit m_done[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = C; m_s1[d] = 0; m_s2[d] = 0; m_win[d] = 0; m_pl[d] = 0; m_done[d] = 0;
        end
    endtask

    task automatic mstep(input int d, input bit a, input bit b);
        if (m_done[d]) return;
        if (m_pl[d] > 0) begin
            m_pl[d]--;
            return;
        end
        if (a && !b) begin
            if (m_pos[d] == N - 1) begin
                m_s1[d]++; m_win[d] = 2; m_pos[d] = C;
                if (m_s1[d] == smax[d]) m_done[d] = 1; else m_pl[d] = PAUSE;
            end else m_pos[d]++;
        end else if (b && !a) begin
            if (m_pos[d] == 0) begin
                m_s2[d]++; m_win[d] = 1; m_pos[d] = C;
                if (m_s2[d] == smax[d]) m_done[d] = 1; else m_pl[d] = PAUSE;
            end else m_pos[d]--;
        end
    endtask

    function automatic int exp_leds(input int d);
        if (m_done[d])  return (1 << N) - 1;
        if (m_pl[d] > 0) return 0;
        return 1 << m_pos[d];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".a.leds"},  int'(ia.leds),       exp_leds(0));
        chk({tag, ".a.s1"},    int'(ia.score1),     m_s1[0]);
        chk({tag, ".a.s2"},    int'(ia.score2),     m_s2[0]);
        chk({tag, ".a.win"},   int'(ia.winner),     m_win[0]);
        chk({tag, ".a.over"},  int'(ia.match_over), int'(m_done[0]));
        chk({tag, ".b.leds"},  int'(ib.leds),       exp_leds(1));
        chk({tag, ".b.s1"},    int'(ib.score1),     m_s1[1]);
        chk({tag, ".b.s2"},    int'(ib.score2),     m_s2[1]);
        chk({tag, ".b.win"},   int'(ib.winner),     m_win[1]);
        chk({tag, ".b.over"},  int'(ib.match_over), int'(m_done[1]));
    endtask

    // Called at a negedge: drive, let the posedge sample, check at the next negedge.
    task automatic cyc(input string tag, input bit a1, input bit a2, input bit b1, input bit b2);
        ia.p1 = a1; ia.p2 = a2; ib.p1 = b1; ib.p2 = b2;
        @(posedge clk);
        mstep(0, a1, a2);
        mstep(1, b1, b2);
        @(negedge clk);
        ia.p1 = 0; ia.p2 = 0; ib.p1 = 0; ib.p2 = 0;
        check_all(tag);
    endtask

    // Asynchronous reset mid-cycle; outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        mreset();
        #1 check_all(tag);
        chk({tag, ".leds_c"}, int'(ia.leds), 9'b000010000);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        ia.p1 = 0; ia.p2 = 0; ib.p1 = 0; ib.p2 = 0;
        mreset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc("idle", 0, 0, 0, 0);
        do_reset("rst0");

        // P1 push-out on the default instance
        repeat (4) cyc("p1walk", 1, 0, 0, 0);
        chk("push4", int'(ia.leds), 9'b100000000);
        cyc("p1win", 1, 0, 0, 0);
        chk("win.leds", int'(ia.leds), 0);
        chk("win.s1", int'(ia.score1), 1);
        chk("win.winner", int'(ia.winner), 2'b10);
        repeat (4) cyc("pause", 0, 0, 0, 0);
        chk("recentre", int'(ia.leds), 9'b000010000);

        // Tie and walking
        cyc("tie", 1, 1, 0, 0);
        chk("tie.leds", int'(ia.leds), 9'b000010000);
        cyc("p2step", 0, 1, 0, 0);
        chk("p2step.leds", int'(ia.leds), 9'b000001000);
        cyc("p1step", 1, 0, 0, 0);
        chk("p1step.leds", int'(ia.leds), 9'b000010000);

        // Pause blanking with a pulse on every pause cycle
        repeat (5) cyc("p1push", 1, 0, 0, 0);
        for (int i = 0; i < PAUSE; i++) cyc("pblank", i[0], ~i[0], 0, 0);
        chk("pblank.s1", int'(ia.score1), 2);
        cyc("postpause", 0, 1, 0, 0);
        chk("postpause.leds", int'(ia.leds), 9'b000001000);

        // Match end on the SCORE_MAX=2 instance
        repeat (5) cyc("b.r1", 0, 0, 0, 1);
        repeat (4) cyc("b.gap", 0, 0, 0, 0);
        repeat (5) cyc("b.r2", 0, 0, 0, 1);
        chk("done.s2", int'(ib.score2), 2);
        chk("done.over", int'(ib.match_over), 1);
        chk("done.leds", int'(ib.leds), 9'h1ff);
        for (int i = 0; i < 6; i++) cyc("done.hold", 0, 0, i[0], ~i[0]);
        chk("done.win", int'(ib.winner), 2'b01);
        do_reset("rst_done");

        // Reset two cycles into PAUSE
        repeat (5) cyc("a.push", 1, 0, 0, 0);
        repeat (2) cyc("a.inpause", 0, 0, 0, 0);
        do_reset("rst_pause");
        cyc("a.first", 1, 0, 0, 0);
        chk("first.leds", int'(ia.leds), 9'b000100000);
        chk("first.s1", int'(ia.score1), 0);

        // Random pulses with a drifting bias so rounds are won both ways
        for (int blk = 0; blk < 12; blk++) begin
            int bias_a, bias_b;
            bias_a = $urandom_range(10, 70);
            bias_b = $urandom_range(10, 70);
            for (int i = 0; i < 250; i++) begin
                bit a1, a2, b1, b2;
                a1 = ($urandom_range(0, 99) < bias_a);
                a2 = ($urandom_range(0, 99) < 80 - bias_a);
                b1 = ($urandom_range(0, 99) < bias_b);
                b2 = ($urandom_range(0, 99) < 80 - bias_b);
                cyc("rnd", a1, a2, b1, b2);
            end
            if (m_done[0] || m_done[1] || $urandom_range(0, 3) == 0) do_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
